// File: rtl/atm_pkg.sv
// Shared definitions for the ATM terminal-side transaction driver:
// core state/operation codes, response status, driver FSM states.
package atm_pkg;

   typedef enum logic [2:0] {
      CS_IDLE       = 3'd0,
      CS_WAITING    = 3'd1,
      CS_MENU       = 3'd2,
      CS_BALANCE    = 3'd3,
      CS_WITHDRAW   = 3'd4,
      CS_DEPOSIT    = 3'd5,
      CS_CHANGE_PIN = 3'd6,
      CS_AUTH       = 3'd7
   } core_state_e;

   // Operation codes deliberately equal the core state they lead to.
   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_BALANCE    = 3'd3;
   localparam logic [2:0] OP_WITHDRAW   = 3'd4;
   localparam logic [2:0] OP_DEPOSIT    = 3'd5;
   localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

   typedef enum logic [1:0] {
      RSP_OK        = 2'd0,
      RSP_AUTH_FAIL = 2'd1,
      RSP_TIMEOUT   = 2'd2,
      RSP_BAD_OP    = 2'd3
   } rsp_status_e;

   typedef enum logic [2:0] {
      D_IDLE    = 3'd0,
      D_AUTH    = 3'd1,
      D_EXEC    = 3'd2,
      D_RELEASE = 3'd3,
      D_RESP    = 3'd4
   } drv_state_e;

   localparam logic [3:0] IDLE_ACC_DEFAULT = 4'hF;

   function automatic logic is_txn_op(input logic [2:0] op);
      return (op == OP_BALANCE) || (op == OP_WITHDRAW) ||
             (op == OP_DEPOSIT) || (op == OP_CHANGE_PIN);
   endfunction

endpackage

// File: rtl/atm_phase_timer.sv
// Wait-phase watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT_CYCLES.
module atm_phase_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != W'(TIMEOUT_CYCLES))) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Asserted during the TIMEOUT_CYCLES-th enabled cycle so the abort lands
   // exactly TIMEOUT_CYCLES cycles after entering the phase.
   assign expired_o = en_i && (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/atm_txn_driver.sv
// Terminal-side initiator: takes one request, walks the ATM core through
// authentication and the requested operation, and returns its result.
module atm_txn_driver
   import atm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [3:0]  IDLE_ACC       = IDLE_ACC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [3:0]  req_acc,
   input  logic [15:0] req_pin,
   input  logic [15:0] req_new_pin,
   input  logic [31:0] req_amount,
   input  logic        req_lang,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_status,
   output logic        rsp_success,
   output logic [31:0] rsp_balance,
   output logic [2:0]  atm_operation,
   output logic [3:0]  atm_acc_num,
   output logic [15:0] atm_pin,
   output logic [15:0] atm_new_pin,
   output logic [31:0] atm_amount,
   output logic        atm_language,
   input  logic [2:0]  atm_state,
   input  logic [31:0] atm_balance,
   input  logic        atm_success
);

   drv_state_e  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic        seen_auth_q, seen_auth_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   rsp_status_e rsp_status_q, rsp_status_d;
   logic        rsp_success_q, rsp_success_d;
   logic [31:0] rsp_balance_q, rsp_balance_d;
   logic [2:0]  atm_op_q, atm_op_d;
   logic [3:0]  acc_q, acc_d;
   logic [15:0] pin_q, pin_d;
   logic [15:0] new_pin_q, new_pin_d;
   logic [31:0] amount_q, amount_d;
   logic        lang_q, lang_d;

   logic        timer_clr;
   logic        timer_en;
   logic        timer_expired;
   logic        do_timeout;

   assign timer_clr = (state_d != state_q);
   assign timer_en  = (state_q == D_AUTH) || (state_q == D_EXEC) ||
                      (state_q == D_RELEASE);

   atm_phase_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (timer_clr),
      .en_i     (timer_en),
      .expired_o(timer_expired)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      seen_auth_d   = seen_auth_q;
      rsp_status_d  = rsp_status_q;
      rsp_success_d = rsp_success_q;
      rsp_balance_d = rsp_balance_q;
      atm_op_d      = atm_op_q;
      acc_d         = acc_q;
      pin_d         = pin_q;
      new_pin_d     = new_pin_q;
      amount_d      = amount_q;
      lang_d        = lang_q;
      do_timeout    = 1'b0;

      unique case (state_q)
         D_IDLE: begin
            if (req_valid && req_ready_q) begin
               seen_auth_d   = 1'b0;
               rsp_success_d = 1'b0;
               rsp_balance_d = '0;
               if (is_txn_op(req_op)) begin
                  op_d         = req_op;
                  acc_d        = req_acc;
                  pin_d        = req_pin;
                  new_pin_d    = req_new_pin;
                  amount_d     = req_amount;
                  lang_d       = req_lang;
                  rsp_status_d = RSP_OK;
                  state_d      = D_AUTH;
               end else begin
                  rsp_status_d = RSP_BAD_OP;
                  state_d      = D_RESP;
               end
            end
         end
         D_AUTH: begin
            if (atm_state == CS_MENU) begin
               atm_op_d = op_q;
               state_d  = D_EXEC;
            end else if (seen_auth_q && (atm_state == CS_WAITING)) begin
               // Core bounced back to WAITING after checking the PIN: rejected.
               rsp_status_d = RSP_AUTH_FAIL;
               atm_op_d     = OP_NOP;
               acc_d        = IDLE_ACC;
               state_d      = D_RELEASE;
            end else begin
               if (atm_state == CS_AUTH) begin
                  seen_auth_d = 1'b1;
               end
               do_timeout = timer_expired;
            end
         end
         D_EXEC: begin
            if (atm_state == op_q) begin
               rsp_success_d = atm_success;
               rsp_balance_d = atm_balance;
               atm_op_d      = OP_NOP;
               acc_d         = IDLE_ACC;
               state_d       = D_RELEASE;
            end else begin
               do_timeout = timer_expired;
            end
         end
         D_RELEASE: begin
            if (atm_state == CS_WAITING) begin
               state_d = D_RESP;
            end else begin
               do_timeout = timer_expired;
            end
         end
         D_RESP: begin
            if (rsp_ready) begin
               state_d = D_IDLE;
            end
         end
         default: begin
            state_d = D_IDLE;
         end
      endcase

      if (do_timeout) begin
         rsp_status_d  = RSP_TIMEOUT;
         rsp_success_d = 1'b0;
         rsp_balance_d = '0;
         atm_op_d      = OP_NOP;
         acc_d         = IDLE_ACC;
         state_d       = D_RESP;
      end
   end

   // Handshake flags are registered from the next state so they line up
   // with the state they describe.
   assign req_ready_d = (state_d == D_IDLE);
   assign rsp_valid_d = (state_d == D_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= D_IDLE;
         op_q          <= OP_NOP;
         seen_auth_q   <= 1'b0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= RSP_OK;
         rsp_success_q <= 1'b0;
         rsp_balance_q <= '0;
         atm_op_q      <= OP_NOP;
         acc_q         <= IDLE_ACC;
         pin_q         <= '0;
         new_pin_q     <= '0;
         amount_q      <= '0;
         lang_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         seen_auth_q   <= seen_auth_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_status_q  <= rsp_status_d;
         rsp_success_q <= rsp_success_d;
         rsp_balance_q <= rsp_balance_d;
         atm_op_q      <= atm_op_d;
         acc_q         <= acc_d;
         pin_q         <= pin_d;
         new_pin_q     <= new_pin_d;
         amount_q      <= amount_d;
         lang_q        <= lang_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_status    = rsp_status_q;
   assign rsp_success   = rsp_success_q;
   assign rsp_balance   = rsp_balance_q;
   assign atm_operation = atm_op_q;
   assign atm_acc_num   = acc_q;
   assign atm_pin       = pin_q;
   assign atm_new_pin   = new_pin_q;
   assign atm_amount    = amount_q;
   assign atm_language  = lang_q;

endmodule

// File: tb/tb_atm_txn_driver.sv
// Bench for atm_txn_driver: behavioural ATM core stub plus a response
// scoreboard fed by the stimulus process and drained by a monitor.
module tb_atm_txn_driver;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [3:0]  req_acc;
   logic [15:0] req_pin;
   logic [15:0] req_new_pin;
   logic [31:0] req_amount;
   logic        req_lang;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_status;
   logic        rsp_success;
   logic [31:0] rsp_balance;
   logic [2:0]  atm_operation;
   logic [3:0]  atm_acc_num;
   logic [15:0] atm_pin;
   logic [15:0] atm_new_pin;
   logic [31:0] atm_amount;
   logic        atm_language;
   logic [2:0]  atm_state;
   logic [31:0] atm_balance;
   logic        atm_success;

   atm_txn_driver #(
      .TIMEOUT_CYCLES(8),
      .IDLE_ACC      (4'hF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_acc      (req_acc),
      .req_pin      (req_pin),
      .req_new_pin  (req_new_pin),
      .req_amount   (req_amount),
      .req_lang     (req_lang),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_status   (rsp_status),
      .rsp_success  (rsp_success),
      .rsp_balance  (rsp_balance),
      .atm_operation(atm_operation),
      .atm_acc_num  (atm_acc_num),
      .atm_pin      (atm_pin),
      .atm_new_pin  (atm_new_pin),
      .atm_amount   (atm_amount),
      .atm_language (atm_language),
      .atm_state    (atm_state),
      .atm_balance  (atm_balance),
      .atm_success  (atm_success)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ATM core stub ----------------
   logic [2:0]  core_st;
   logic [31:0] core_bal;
   logic        core_succ;
   logic        core_hold;
   logic [15:0] db_pin [16] = '{16'h0000, 16'h1111, 16'h1234, 16'h2222, 16'h3333, 16'h4444,
                               16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h0, 16'h0,
                               16'h0, 16'h0, 16'h0, 16'h0};
   logic [31:0] db_bal [16] = '{32'd10, 32'd20, 32'd500, 32'd40, 32'd50, 32'd60,
                               32'd70, 32'd80, 32'd90, 32'd100, 32'd0, 32'd0,
                               32'd0, 32'd0, 32'd0, 32'd0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_st   <= 3'd0;
         core_bal  <= 32'd0;
         core_succ <= 1'b0;
      end else if (!core_hold) begin
         case (core_st)
            3'd0: core_st <= 3'd1;
            3'd1: if (atm_acc_num < 4'd10) core_st <= 3'd7;
            3'd7: begin
               if ((atm_acc_num < 4'd10) && (atm_pin == db_pin[atm_acc_num])) core_st <= 3'd2;
               else core_st <= 3'd1;
            end
            3'd2: begin
               if (atm_operation >= 3'd3 && atm_operation <= 3'd6) begin
                  core_st   <= atm_operation;
                  core_succ <= 1'b1;
                  core_bal  <= db_bal[atm_acc_num];
                  if (atm_operation == 3'd4) begin
                     if (atm_amount <= db_bal[atm_acc_num]) begin
                        db_bal[atm_acc_num] <= db_bal[atm_acc_num] - atm_amount;
                        core_bal <= db_bal[atm_acc_num] - atm_amount;
                     end else begin
                        core_succ <= 1'b0;
                     end
                  end else if (atm_operation == 3'd5) begin
                     db_bal[atm_acc_num] <= db_bal[atm_acc_num] + atm_amount;
                     core_bal <= db_bal[atm_acc_num] + atm_amount;
                  end else if (atm_operation == 3'd6) begin
                     db_pin[atm_acc_num] <= atm_new_pin;
                  end
               end
            end
            default: core_st <= 3'd1;
         endcase
      end
   end

   assign atm_state   = core_st;
   assign atm_balance = core_bal;
   assign atm_success = core_succ;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [1:0]  st;
      logic        succ;
      logic [31:0] bal;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 128'(rsp_status), 128'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("rsp_status",  128'(rsp_status),  128'(e.st));
               check("rsp_success", 128'(rsp_success), 128'(e.succ));
               check("rsp_balance", 128'(rsp_balance), 128'(e.bal));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [127:0] pack_outs();
      return 128'({req_ready, rsp_valid, rsp_status, rsp_success, rsp_balance, atm_operation,
                   atm_acc_num, atm_pin, atm_new_pin, atm_amount, atm_language});
   endfunction

   localparam logic [127:0] RESET_OUTS =
      128'({1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 4'hF, 16'd0, 16'd0, 32'd0, 1'b0});

   task automatic push(input logic [1:0] st, input logic succ, input logic [31:0] bal);
      exp_t e;
      e.st = st; e.succ = succ; e.bal = bal;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] pin,
                       input logic [15:0] npin, input logic [31:0] amt);
      int k;
      @(posedge clk); #1;
      req_op = op; req_acc = acc; req_pin = pin; req_new_pin = npin;
      req_amount = amt; req_lang = 1'b1; req_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("req_accept", 128'(req_ready), 128'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && req_ready) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(name, 128'(exp_q.size() == 0 && req_ready), 128'(1));
   endtask

   initial begin
      int  n;
      logic ok;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_acc = '0; req_pin = '0;
      req_new_pin = '0; req_amount = '0; req_lang = 1'b0; rsp_ready = 1'b1; core_hold = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", pack_outs(), RESET_OUTS);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_outputs", pack_outs(), RESET_OUTS);

      // Balance, passing through AUTHENTICATION
      push(2'd0, 1'b1, 32'd500);
      send(3'd3, 4'd2, 16'h1234, 16'h0, 32'd0);
      n = 0;
      while (atm_state != 3'd7 && n < 20) begin @(negedge clk); n++; end
      check("core_saw_auth", 128'(atm_state), 128'(7));
      wait_done("balance_done");

      push(2'd0, 1'b0, 32'd500);
      send(3'd4, 4'd2, 16'h1234, 16'h0, 32'd600);
      wait_done("withdraw_done");
      push(2'd0, 1'b1, 32'd750);
      send(3'd5, 4'd2, 16'h1234, 16'h0, 32'd250);
      wait_done("deposit_done");
      push(2'd0, 1'b1, 32'd750);
      send(3'd3, 4'd2, 16'h1234, 16'h0, 32'd0);
      wait_done("balance2_done");

      // Wrong PIN, with response back-pressure
      rsp_ready = 1'b0;
      push(2'd1, 1'b0, 32'd0);
      send(3'd3, 4'd2, 16'h9999, 16'h0, 32'd0);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("authfail_acc_idle", 128'(atm_acc_num), 128'(4'hF));
      for (int i = 0; i < 5; i++) begin
         check("hold_stable", 128'({rsp_valid, req_ready, rsp_status, rsp_success, rsp_balance}),
               128'({1'b1, 1'b0, 2'd1, 1'b0, 32'd0}));
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_done("authfail_done");

      push(2'd0, 1'b1, 32'd750);
      send(3'd6, 4'd2, 16'h1234, 16'h5678, 32'd0);
      wait_done("chpin_done");
      push(2'd0, 1'b1, 32'd750);
      send(3'd3, 4'd2, 16'h5678, 16'h0, 32'd0);
      wait_done("newpin_done");

      // Unsupported operations
      push(2'd3, 1'b0, 32'd0);
      send(3'd7, 4'd2, 16'h5678, 16'h0, 32'd0);
      @(negedge clk);
      check("badop_latency", 128'({rsp_valid, atm_acc_num}), 128'({1'b1, 4'hF}));
      wait_done("badop7_done");
      push(2'd3, 1'b0, 32'd0);
      send(3'd0, 4'd2, 16'h5678, 16'h0, 32'd0);
      @(negedge clk);
      check("badop0_latency", 128'({rsp_valid, atm_acc_num}), 128'({1'b1, 4'hF}));
      wait_done("badop0_done");

      // Frozen core: TIMEOUT after 8 cycles in D_AUTH
      @(posedge clk); #1;
      core_hold = 1'b1;
      push(2'd2, 1'b0, 32'd0);
      send(3'd3, 4'd2, 16'h5678, 16'h0, 32'd0);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; break; end
         n++;
      end
      check("timeout_latency", 128'({ok, 8'(n)}), 128'({1'b1, 8'd8}));
      check("timeout_acc_idle", 128'({atm_acc_num, atm_operation}), 128'({4'hF, 3'd0}));
      wait_done("timeout_done");
      @(posedge clk); #1;
      core_hold = 1'b0;

      // Reset while waiting in D_EXEC
      send(3'd3, 4'd2, 16'h5678, 16'h0, 32'd0);
      n = 0;
      while (atm_state != 3'd2 && n < 30) begin @(negedge clk); n++; end
      core_hold = 1'b1;
      n = 0;
      while (atm_operation != 3'd3 && n < 30) begin @(negedge clk); n++; end
      check("exec_reached", 128'(atm_operation), 128'(3));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midtxn_reset_outputs", pack_outs(), RESET_OUTS);
      @(posedge clk); @(posedge clk); #1;
      core_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1'b1;
      end
      check("no_rsp_after_reset", 128'({ok, req_ready}), 128'({1'b0, 1'b1}));

      push(2'd0, 1'b1, 32'd750);
      send(3'd3, 4'd2, 16'h5678, 16'h0, 32'd0);
      wait_done("recover_done");

      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
